bip_control_unit: RTL and testbench

Multi-cycle control unit that sequences the accumulator datapath (ACC, ALU, status Z/N, data-memory port) as a BIP-class processor.
- Holds the program counter (PC) and instruction register (IR).
- Fetches 16-bit instructions from a synchronous program ROM and decodes them.
- Drives every datapath control strobe (alu_op, sel_A, sel_B, acc_wr, status_wr, resets) and the data-memory write enable.
- Sits between the program memory and the datapath at the top of the processor.

---
 rtl/bip_pkg.sv | 84 ++++++++
 rtl/bip_control_unit_branch_unit.sv | 26 ++
 rtl/bip_control_unit.sv | 109 ++++++++++
 tb/tb_bip_control_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// BIP control unit shared types: opcodes, FSM states, datapath select codes.
// Strobe decode helpers used by bip_control_unit.
package bip_pkg;

  localparam int OP_BITS = 5;

  typedef enum logic [OP_BITS-1:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_BGT  = 5'b01010,
    OP_BGE  = 5'b01011,
    OP_BLT  = 5'b01100,
    OP_BLE  = 5'b01101,
    OP_JMP  = 5'b01110
  } opcode_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_MEM_READ,
    S_EXECUTE,
    S_HALT
  } state_t;

  localparam logic [1:0] SEL_A_MEM     = 2'b00;
  localparam logic [1:0] SEL_A_OPERAND = 2'b01;
  localparam logic [1:0] SEL_A_ALU     = 2'b10;
  localparam logic SEL_B_MEM     = 1'b0;
  localparam logic SEL_B_OPERAND = 1'b1;
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef struct packed {
    logic       alu_op;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       acc_wr;
    logic       status_wr;
    logic       mem_wr;
  } strobe_t;

  function automatic logic needs_mem(input logic [OP_BITS-1:0] op);
    return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic strobe_t decode_strobes(
    input logic [OP_BITS-1:0] op
  );
    strobe_t s;
    s = '0;
    case (op)
      OP_STO: s.mem_wr = 1'b1;
      OP_LD: begin
        s.sel_a  = SEL_A_MEM;
        s.acc_wr = 1'b1;
      end
      OP_LDI: begin
        s.sel_a  = SEL_A_OPERAND;
        s.acc_wr = 1'b1;
      end
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
        s.sel_a     = SEL_A_ALU;
        s.acc_wr    = 1'b1;
        s.status_wr = 1'b1;
        s.sel_b  = (op == OP_ADDI || op == OP_SUBI)
                 ? SEL_B_OPERAND : SEL_B_MEM;
        s.alu_op = (op == OP_SUB || op == OP_SUBI)
                 ? ALU_SUB : ALU_ADD;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bip_control_unit_branch_unit.sv
// Branch condition evaluation from opcode and Z/N status flags.
// JMP reports taken unconditionally; non-branch opcodes never do.
module bip_branch_unit
  import bip_pkg::*;
(
  input  logic [OP_BITS-1:0] opcode,
  input  logic               flag_z,
  input  logic               flag_n,
  output logic               taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = flag_z;
      OP_BNE:  taken = !flag_z;
      OP_BGT:  taken = !flag_z && !flag_n;
      OP_BGE:  taken = !flag_n;
      OP_BLT:  taken = flag_n;
      OP_BLE:  taken = flag_z || flag_n;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// Multi-cycle BIP control unit: PC, IR, FSM and datapath strobe decoder.
// Optional BIP_SINGLE_STEP_EN adds step_in / step_wait_out gating of FETCH.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int DATA_WIDTH   = 11,
  parameter int OPCODE_WIDTH = 5,
  parameter int ADDR_WIDTH   = 11
) (
  input  logic                             clock_in,
  input  logic                             reset_in,
  input  logic [OPCODE_WIDTH+DATA_WIDTH-1:0] instruction_in,
  input  logic                             flag_Z_in,
  input  logic                             flag_N_in,
`ifdef BIP_SINGLE_STEP_EN
  input  logic                             step_in,
  output logic                             step_wait_out,
`endif
  output logic [ADDR_WIDTH-1:0]            program_address_out,
  output logic [DATA_WIDTH-1:0]            operand_out,
  output logic                             alu_op_out,
  output logic [1:0]                       sel_A_out,
  output logic                             sel_B_out,
  output logic                             acc_wr_out,
  output logic                             acc_reset_out,
  output logic                             status_wr_out,
  output logic                             status_reset_out,
  output logic                             data_memory_wr_out,
  output logic                             halted_out
);

  localparam int IW = OPCODE_WIDTH + DATA_WIDTH;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [IW-1:0]         ir;
  strobe_t               strb;
  logic [OP_BITS-1:0]    ir_op;
  logic [OP_BITS-1:0]    in_op;
  logic                  taken;
  logic                  step_go;

  assign ir_op = ir[IW-1 -: OP_BITS];
  assign in_op = instruction_in[IW-1 -: OP_BITS];

`ifdef BIP_SINGLE_STEP_EN
  assign step_go       = step_in;
  assign step_wait_out = (state == S_FETCH);
`else
  assign step_go = 1'b1;
`endif

  bip_branch_unit u_branch (
    .opcode (ir_op),
    .flag_z (flag_Z_in),
    .flag_n (flag_N_in),
    .taken  (taken)
  );

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
      strb  <= '0;
    end else begin
      strb <= '0;
      unique case (state)
        S_INIT:  state <= S_FETCH;
        S_FETCH: if (step_go) state <= S_DECODE;
        S_DECODE: begin
          ir <= instruction_in;
          pc <= pc + ADDR_WIDTH'(1);
          if (needs_mem(in_op)) begin
            state <= S_MEM_READ;
          end else begin
            state <= S_EXECUTE;
            strb  <= decode_strobes(in_op);
          end
        end
        S_MEM_READ: begin
          state <= S_EXECUTE;
          strb  <= decode_strobes(ir_op);
        end
        S_EXECUTE: begin
          if (taken) pc <= ADDR_WIDTH'(ir[DATA_WIDTH-1:0]);
          state <= (ir_op == OP_HLT) ? S_HALT : S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_INIT;
      endcase
    end
  end

  // Strobes are masked while reset is low so an aborted store never lands.
  assign alu_op_out         = strb.alu_op    & reset_in;
  assign sel_A_out          = strb.sel_a     & {2{reset_in}};
  assign sel_B_out          = strb.sel_b     & reset_in;
  assign acc_wr_out         = strb.acc_wr    & reset_in;
  assign status_wr_out      = strb.status_wr & reset_in;
  assign data_memory_wr_out = strb.mem_wr    & reset_in;

  assign acc_reset_out       = (state == S_INIT);
  assign status_reset_out    = (state == S_INIT);
  assign halted_out          = (state == S_HALT);
  assign program_address_out = pc;
  assign operand_out         = ir[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed testbench for bip_control_unit with ROM and datapath models.
// Define BIP_SINGLE_STEP_EN to also exercise single-step gating.
module tb_bip_control_unit;

  logic        clk;
  logic        reset_in;
  logic [15:0] instr;
  logic        flag_z;
  logic        flag_n;
  logic        step_in;
  logic        step_wait;
  logic [10:0] addr;
  logic [10:0] operand;
  logic        alu_op;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        acc_wr;
  logic        acc_rst;
  logic        st_wr;
  logic        st_rst;
  logic        mem_wr;
  logic        halted;

  int errors = 0;
  int checks = 0;

  logic [15:0] rom [0:2047];
  logic [10:0] dmem [0:2047];
  logic [10:0] acc, mem_q, alu_b, alu_y;
  logic        mz, mn;
  logic        force_flags, fz, fn;
  logic        dm_init_en;
  logic [10:0] dm_init_addr, dm_init_data;
  int          wr_count = 0;
  logic [10:0] wr_addr, wr_data;
  logic [6:0]  strb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bip_control_unit dut (
    .clock_in            (clk),
    .reset_in            (reset_in),
    .instruction_in      (instr),
    .flag_Z_in           (flag_z),
    .flag_N_in           (flag_n),
`ifdef BIP_SINGLE_STEP_EN
    .step_in             (step_in),
    .step_wait_out       (step_wait),
`endif
    .program_address_out (addr),
    .operand_out         (operand),
    .alu_op_out          (alu_op),
    .sel_A_out           (sel_a),
    .sel_B_out           (sel_b),
    .acc_wr_out          (acc_wr),
    .acc_reset_out       (acc_rst),
    .status_wr_out       (st_wr),
    .status_reset_out    (st_rst),
    .data_memory_wr_out  (mem_wr),
    .halted_out          (halted)
  );

`ifndef BIP_SINGLE_STEP_EN
  assign step_wait = 1'b0;
`endif

  assign strb   = {alu_op, sel_a, sel_b, acc_wr, st_wr, mem_wr};
  assign flag_z = force_flags ? fz : mz;
  assign flag_n = force_flags ? fn : mn;
  assign alu_b  = sel_b ? operand : mem_q;
  assign alu_y  = alu_op ? acc - alu_b : acc + alu_b;

  always @(posedge clk) instr <= rom[addr];

  always @(posedge clk) begin
    mem_q <= dmem[operand];
    if (acc_rst) acc <= '0;
    else if (acc_wr)
      acc <= (sel_a == 2'b00) ? mem_q :
             (sel_a == 2'b01) ? operand : alu_y;
    if (st_rst) begin
      mz <= 1'b0;
      mn <= 1'b0;
    end else if (st_wr) begin
      mz <= (alu_y == 11'd0);
      mn <= alu_y[10];
    end
    if (dm_init_en) dmem[dm_init_addr] <= dm_init_data;
    if (mem_wr) begin
      dmem[operand] <= acc;
      wr_count <= wr_count + 1;
      wr_addr  <= operand;
      wr_data  <= acc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
  endtask

  // Leaves the bench in the INIT cycle right after reset release.
  task automatic do_reset();
    reset_in    = 1'b0;
    force_flags = 1'b0;
    repeat (3) tick();
    reset_in = 1'b1;
  endtask

  task automatic test_reset();
    clear_rom();
    reset_in = 1'b0;
    repeat (3) tick();
    checks++;
    if (acc_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold acc_reset got=%b want=1", acc_rst);
    end
    reset_in = 1'b1;
    checks++;
    if ({acc_rst, st_rst, halted} !== 3'b110) begin
      errors++;
      $display("FAIL init_resets got=%b want=110",
               {acc_rst, st_rst, halted});
    end
    checks++;
    if (strb !== 7'd0 || addr !== 11'd0) begin
      errors++;
      $display("FAIL init_strobes strb=%b addr=%h want 0/000",
               strb, addr);
    end
    tick();
    checks++;
    if ({acc_rst, st_rst} !== 2'b00 || addr !== 11'd0) begin
      errors++;
      $display("FAIL fetch_after_init rst=%b addr=%h want 00/000",
               {acc_rst, st_rst}, addr);
    end
  endtask

  task automatic test_program();
    int n;
    int w0;
    clear_rom();
    rom[0] = {5'b00011, 11'd5};
    rom[1] = {5'b00101, 11'd3};
    rom[2] = {5'b00001, 11'h010};
    rom[3] = {5'b00000, 11'd0};
    do_reset();
    w0 = wr_count;
    n  = 0;
    while (!halted && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (halted !== 1'b1 || n != 13) begin
      errors++;
      $display("FAIL halt_latency got=%0d halted=%b want=13", n, halted);
    end
    checks++;
    if (wr_count - w0 != 1 || wr_addr !== 11'h010
        || wr_data !== 11'd8) begin
      errors++;
      $display("FAIL store n=%0d addr=%h data=%0d want 1/010/8",
               wr_count - w0, wr_addr, wr_data);
    end
    repeat (5) tick();
    checks++;
    if (addr !== 11'd4 || halted !== 1'b1 || strb !== 7'd0) begin
      errors++;
      $display("FAIL halt_frozen addr=%h halted=%b strb=%b want 004/1/0",
               addr, halted, strb);
    end
  endtask

  task automatic test_mem_ops();
    clear_rom();
    rom[0] = {5'b00010, 11'h004};
    rom[1] = {5'b00110, 11'h004};
    rom[2] = {5'b01000, 11'h020};
    reset_in     = 1'b0;
    dm_init_en   = 1'b1;
    dm_init_addr = 11'h004;
    dm_init_data = 11'd7;
    tick();
    dm_init_en = 1'b0;
    do_reset();
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 3 || t == 7) begin
        checks++;
        if (strb !== 7'd0) begin
          errors++;
          $display("FAIL mem_read_quiet t=%0d strb=%b want 0", t, strb);
        end
      end
      if (t == 4) begin
        checks++;
        if (strb !== 7'b0_00_0_1_0_0) begin
          errors++;
          $display("FAIL ld_exec strb=%b want 0000100", strb);
        end
      end
      if (t == 8) begin
        checks++;
        if (strb !== 7'b1_10_0_1_1_0) begin
          errors++;
          $display("FAIL sub_exec strb=%b want 1100110", strb);
        end
      end
      if (t == 9) begin
        checks++;
        if (acc !== 11'd0 || mz !== 1'b1 || addr !== 11'd2) begin
          errors++;
          $display("FAIL sub_result acc=%0d z=%b addr=%h want 0/1/002",
                   acc, mz, addr);
        end
      end
      if (t == 12) begin
        checks++;
        if (addr !== 11'h020) begin
          errors++;
          $display("FAIL beq_target got=%h want=020", addr);
        end
      end
    end
  endtask

  task automatic test_branches();
    logic [4:0]  br_op  [0:6];
    logic [2:0]  br_exp [0:6];
    logic [10:0] want;
    br_op[0] = 5'b01000; br_exp[0] = 3'b100;
    br_op[1] = 5'b01001; br_exp[1] = 3'b011;
    br_op[2] = 5'b01010; br_exp[2] = 3'b001;
    br_op[3] = 5'b01011; br_exp[3] = 3'b101;
    br_op[4] = 5'b01100; br_exp[4] = 3'b010;
    br_op[5] = 5'b01101; br_exp[5] = 3'b110;
    br_op[6] = 5'b01110; br_exp[6] = 3'b111;
    clear_rom();
    for (int b = 0; b < 7; b++) begin
      for (int k = 0; k < 3; k++) begin
        rom[0] = {br_op[b], 11'h155};
        do_reset();
        force_flags = 1'b1;
        fz = (k == 2);
        fn = (k == 1);
        repeat (3) tick();
        checks++;
        if (strb !== 7'd0) begin
          errors++;
          $display("FAIL br_strobes op=%b strb=%b want 0", br_op[b], strb);
        end
        tick();
        want = br_exp[b][k] ? 11'h155 : 11'h001;
        checks++;
        if (addr !== want) begin
          errors++;
          $display("FAIL branch op=%b zn=%b%b got=%h want=%h",
                   br_op[b], fz, fn, addr, want);
        end
      end
    end
    force_flags = 1'b0;
  endtask

  task automatic test_wrap_nop();
    clear_rom();
    rom[0]     = {5'b01110, 11'h7FF};
    rom[11'h7FF] = {5'b00101, 11'd1};
    do_reset();
    repeat (4) tick();
    checks++;
    if (addr !== 11'h7FF) begin
      errors++;
      $display("FAIL jmp_top got=%h want=7ff", addr);
    end
    repeat (2) tick();
    checks++;
    if (strb !== 7'b0_10_1_1_1_0) begin
      errors++;
      $display("FAIL addi_exec strb=%b want 0101110", strb);
    end
    tick();
    checks++;
    if (addr !== 11'h000) begin
      errors++;
      $display("FAIL pc_wrap got=%h want=000", addr);
    end
    clear_rom();
    rom[0] = {5'b11010, 11'h3AB};
    do_reset();
    repeat (3) tick();
    checks++;
    if (strb !== 7'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL nop_exec strb=%b halted=%b want 0/0", strb, halted);
    end
    tick();
    checks++;
    if (addr !== 11'h001) begin
      errors++;
      $display("FAIL nop_next got=%h want=001", addr);
    end
  endtask

  task automatic test_reset_abort();
    int w0;
    clear_rom();
    rom[0] = {5'b00001, 11'h010};
    do_reset();
    w0 = wr_count;
    repeat (3) tick();
    reset_in = 1'b0;
    #1;
    checks++;
    if (mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL abort_strobe got=%b want=0", mem_wr);
    end
    tick();
    checks++;
    if (wr_count != w0 || acc_rst !== 1'b1) begin
      errors++;
      $display("FAIL abort_state writes=%0d init=%b want 0/1",
               wr_count - w0, acc_rst);
    end
    reset_in = 1'b1;
  endtask

`ifdef BIP_SINGLE_STEP_EN
  task automatic test_single_step();
    int pulses;
    clear_rom();
    rom[0] = {5'b00011, 11'd1};
    rom[1] = {5'b00011, 11'd2};
    do_reset();
    step_in = 1'b0;
    pulses  = 0;
    repeat (6) begin
      tick();
      if (acc_wr) pulses++;
    end
    checks++;
    if (addr !== 11'd0 || step_wait !== 1'b1 || pulses != 0) begin
      errors++;
      $display("FAIL step_hold addr=%h wait=%b wr=%0d want 000/1/0",
               addr, step_wait, pulses);
    end
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    repeat (8) begin
      tick();
      if (acc_wr) pulses++;
    end
    checks++;
    if (addr !== 11'd1 || step_wait !== 1'b1 || pulses != 1) begin
      errors++;
      $display("FAIL step_one addr=%h wait=%b wr=%0d want 001/1/1",
               addr, step_wait, pulses);
    end
    step_in = 1'b1;
  endtask
`endif

  initial begin
    reset_in    = 1'b0;
    step_in     = 1'b1;
    force_flags = 1'b0;
    fz          = 1'b0;
    fn          = 1'b0;
    dm_init_en  = 1'b0;
    dm_init_addr = '0;
    dm_init_data = '0;
    test_reset();
    test_program();
    test_mem_ops();
    test_branches();
    test_wrap_nop();
    test_reset_abort();
`ifdef BIP_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
